// File: rtl/timer_pkg.sv
// Shared types and constants for the stopwatch/timer control block.
// Count packing is four BCD nibbles, SS.hh, tens of seconds in the top nibble.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  // Nibble positions within the packed count
  localparam int DIG_TS = 3;
  localparam int DIG_S  = 2;
  localparam int DIG_T  = 1;
  localparam int DIG_H  = 0;

  // Force any non-decimal nibble of a preset value down to 9
  function automatic logic [15:0] bcd_clamp(input logic [15:0] raw);
    logic [15:0] r;
    r = raw;
    for (int i = DIG_H; i <= DIG_TS; i++) begin
      if (raw[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd4_updown.sv
// Combinational 4-digit BCD +/-1 stepper with ripple carry/borrow.
// A digit steps only when every lower digit wraps (9 going up, 0 going down).
module bcd4_updown
  import timer_pkg::*;
(
  input  logic [15:0] value,
  input  logic        down,
  output logic [15:0] result,
  output logic        at_max,
  output logic        at_zero
);

  // ripple[k] is high when digit k must step
  logic [3:0] ripple;

  assign ripple[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] nib;
      logic       wraps;
      logic [3:0] stepped;

      assign nib     = value[gi*4 +: 4];
      assign wraps   = down ? (nib == 4'd0) : (nib == 4'd9);
      assign stepped = !ripple[gi] ? nib :
                       down ? (wraps ? 4'd9 : nib - 4'd1) :
                              (wraps ? 4'd0 : nib + 4'd1);
      assign result[gi*4 +: 4] = stepped;

      if (gi < 3) begin : g_chain
        assign ripple[gi+1] = ripple[gi] & wraps;
      end
    end
  endgenerate

  assign at_max  = (value == BCD_MAX);
  assign at_zero = (value == 16'h0000);

endmodule

// File: rtl/timer_controller.sv
// Stopwatch/timer sequencer: IDLE/RUN/PAUSE/DONE FSM, tick prescaler and
// the BCD count register that drives the seven-segment encoders.
// Optional feature macro TIMER_BLINK_EN: blinks `blank` at 2 Hz in DONE;
// without it `blank` is constant 0 and no blink counter exists.
module timer_controller
  import timer_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        resetload,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        load,
  input  logic        mode,
  input  logic [15:0] ld_digits,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        blank
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  timer_state_t  state_reg, state_next;
  logic [15:0]   count_reg, count_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic          mode_reg, mode_next;
  logic          running_reg, done_reg;

  logic          tick;
  logic [15:0]   stepped;
  logic          at_max, at_zero;

  assign tick = (presc_reg == PRESC_LAST);

  bcd4_updown u_step (
    .value   (count_reg),
    .down    (mode_reg),
    .result  (stepped),
    .at_max  (at_max),
    .at_zero (at_zero)
  );

  // Next-state logic; command priority is clear, then load, then start_stop
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    presc_next = presc_reg;
    mode_next  = (state_reg == IDLE) ? mode : mode_reg;

    if (clear) begin
      state_next = IDLE;
      count_next = 16'h0000;
      presc_next = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          presc_next = '0;
          if (load) begin
            count_next = bcd_clamp(ld_digits);
          end else if (start_stop && (!mode || !at_zero)) begin
            state_next = RUN;
          end
        end
        RUN: begin
          presc_next = tick ? '0 : presc_reg + 1'b1;
          if (tick) begin
            if (!mode_reg && at_max) begin
              state_next = DONE;
            end else begin
              count_next = stepped;
              if (mode_reg && (stepped == 16'h0000)) state_next = DONE;
            end
          end
          // Expiry in the same cycle takes precedence over a pause request
          if (start_stop && (state_next == RUN)) state_next = PAUSE;
        end
        PAUSE: begin
          if (start_stop) state_next = RUN;
        end
        DONE: begin
          presc_next = tick ? '0 : presc_reg + 1'b1;
          if (start_stop) begin
            state_next = IDLE;
            count_next = 16'h0000;
            presc_next = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, count, prescaler and registered status flags
  always_ff @(posedge clk or negedge resetload) begin
    if (!resetload) begin
      state_reg   <= IDLE;
      count_reg   <= 16'h0000;
      presc_reg   <= '0;
      mode_reg    <= 1'b0;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      presc_reg   <= presc_next;
      mode_reg    <= mode_next;
      running_reg <= (state_next == RUN);
      done_reg    <= (state_next == DONE);
    end
  end

`ifdef TIMER_BLINK_EN
  localparam int BLINK_TICKS = (TICK_HZ / 4 > 0) ? TICK_HZ / 4 : 1;
  localparam int BW          = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] blink_cnt_reg;
  logic          blank_reg;

  // Blink phase: restarts dark-off on DONE entry, toggles every quarter second
  always_ff @(posedge clk or negedge resetload) begin
    if (!resetload) begin
      blink_cnt_reg <= '0;
      blank_reg     <= 1'b0;
    end else if ((state_reg != DONE) || (state_next != DONE)) begin
      blink_cnt_reg <= '0;
      blank_reg     <= 1'b0;
    end else if (tick) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg <= '0;
        blank_reg     <= ~blank_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  assign blank = blank_reg;
`else
  assign blank = 1'b0;
`endif

  assign digits  = count_reg;
  assign running = running_reg;
  assign done    = done_reg;

endmodule

// File: doc/timer_controller.md
# timer_controller

Control block for the programmable stopwatch/timer. It sequences a 4-digit BCD count (format SS.hh, decimal point after digit 2) in stopwatch (count-up) or timer (count-down) mode. It handles start/stop, clear and preset-load commands, and raises `done` on saturation or expiry. Its `digits` output feeds the per-digit seven-segment encoders ahead of the 4-digit display scan multiplexer; `blank` gates those encoders.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency.
- `TICK_HZ`, 100, count rate in hundredths of a second. `TICK_DIV = CLK_HZ/TICK_HZ` must be ≥ 2.
- `clk`  input  1  single system clock, rising edge.
- `resetload`  input  1  asynchronous, active-low reset.
- `start_stop`  input  1  single-cycle command pulse, already debounced and synchronised upstream.
- `clear`  input  1  single-cycle pulse; forces IDLE and count 00.00.
- `load`  input  1  single-cycle pulse; presets the count from `ld_digits`. Accepted in IDLE only.
- `mode`  input  1  0 = stopwatch up, 1 = timer down. Sampled only in IDLE.
- `ld_digits`  input  16  four BCD nibbles; [15:12] = tens of seconds … [3:0] = hundredths.
- `digits`  output  16  current count in BCD, same packing as `ld_digits`.
- `running`  output  1  high in RUN.
- `done`  output  1  high in DONE.
- `blank`  output  1  display blank request (see Configuration).

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Command priority within one cycle: `clear` > `load` > `start_stop`.
- `clear` in any state: go to IDLE, count 0000, prescaler 0.
- IDLE:
  - `load` latches `ld_digits` into the count. Any nibble > 9 is clamped to 9.
  - `mode` is latched every cycle while in IDLE.
  - `start_stop`:
    - Up mode: go to RUN.
    - Down mode, count nonzero: go to RUN.
    - Down mode, count 0000: ignore.
  - Prescaler is held at 0.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; a tick occurs when it equals TICK_DIV-1, and the prescaler then wraps to 0.
  - On a tick, the BCD count steps by one hundredth with ripple carry/borrow across all four digits (e.g. 09.99 → 10.00, 10.00 → 09.99).
  - Up mode: tick at 99.99 holds 99.99 and goes to DONE.
  - Down mode: tick producing 00.00 goes to DONE.
  - `start_stop`: go to PAUSE. A tick in the same cycle is still applied.
- PAUSE: count and prescaler frozen, preserving the partial interval. `start_stop` returns to RUN.
- DONE: count frozen. Prescaler free-runs for the blink only. `start_stop` goes to IDLE with count 0000.
- `load` outside IDLE is ignored. `mode` changes outside IDLE have no effect.

## Timing
- Reset values: state IDLE, `digits` = 0x0000, `running` = 0, `done` = 0, `blank` = 0, prescaler 0, latched mode 0.
- All outputs are registered; none depend combinationally on inputs.
- Command pulse in cycle n: new state and outputs visible in cycle n+1.
- After IDLE → RUN in cycle n+1, the first tick occurs TICK_DIV cycles later. `digits` changes in the cycle after the tick.
- DONE is entered in the same cycle the final count value appears.
- Reset asserted mid-RUN takes effect immediately; no count is retained.

## Configuration
- `TIMER_BLINK_EN` defined: in DONE, `blank` toggles every TICK_HZ/4 ticks (2 Hz blink). `blank` is 0 on entry to DONE and 0 in every other state.
- Not defined: `blank` is tied to 0 and the blink counter is not built.

## Structure
- Package `timer_pkg` contains:
  - state enum `timer_state_t` (IDLE, RUN, PAUSE, DONE);
  - `BCD_MAX` = 16'h9999;
  - nibble index constants `DIG_TS`, `DIG_S`, `DIG_T`, `DIG_H`.
- One sub-module: `bcd4_updown`, a combinational 4-digit BCD ±1 stepper with `at_max` and `at_zero` flags. The top level holds the FSM, prescaler, registers and blink.

## Test plan
All scenarios use CLK_HZ=1000, TICK_HZ=100 (TICK_DIV=10).
- Reset release, then 3 idle cycles → `digits` 0x0000, `running`/`done`/`blank` all 0.
- Up mode: `start_stop`, run 1000 cycles → `digits` 0x0100. 09.99 → 10.00 carry observed at the correct cycle.
- Load 0x0003, mode 1, `start_stop` → reaches 0x0000 after 30 cycles, `done`=1 the same cycle, count holds. Load 0x0000 then `start_stop` → stays IDLE.
- `start_stop` after 25 cycles → PAUSE at 0x0002; resume → next tick exactly 5 cycles later, giving 0x0003.
- `clear` and `start_stop` in the same cycle during RUN → IDLE, 0x0000. Load of 0xA5F1 → `digits` 0x9591.
- Load 0x9998 up → DONE at 0x9999. With `TIMER_BLINK_EN`, `blank` toggles every 250 cycles. Without it, `blank` stays 0.
